stage3_fetch_stage: RTL
=======================

# stage3_fetch_stage

Fetch stage of the three-stage pipeline. It owns the fetch PC, issues instruction reads on the instruction bus, and fills the IF/EX latch consumed by execute. It is steered by the hazard unit's fetch controls: PC enable, redirect, stall, flush, trap-vector insertion and rollback. It reports bus busy status back to the hazard unit.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC loaded on reset.
- `CLK` in 1: clock.
- `RST` in 1: asynchronous, active-high reset.
- `pc_en`, `npc_sel`, `if_ex_stall`, `if_ex_flush`, `iren`, `suppress_iren`, `rollback`, `insert_priv_pc` in 1 each: hazard-unit controls.
- `priv_pc` in 32: xTVEC / xEPC target.
- `brj_addr` in 32: resolved branch/jump target.
- `pc_m` in 32: PC of the instruction in mem; rollback target is `pc_m`+4.
- `predict_taken` in 1, `predict_target` in 32: branch-predictor output for `pc_f`.
- `imem_addr` out 32, `imem_ren` out 1: instruction bus request.
- `imem_busy` in 1, `imem_rdata` in 32: instruction bus response; data is valid in the cycle `imem_busy`=0.
- `pc_f` out 32: current fetch PC.
- `i_mem_busy` out 1: fetch not complete, to the hazard unit.
- `rv32c_ready` out 1: tied to 1 (RV32C not supported by this stage).
- `fe_valid`, `fe_instr`[32], `fe_pc`[32], `fe_pc4`[32], `fe_pred_taken`, `fe_mal_insn`: IF/EX latch outputs.

## Operation
- FSM states are FETCH and DISCARD.
- **Next-PC priority:**
  - `insert_priv_pc` selects `priv_pc`.
  - else `rollback` selects `pc_m`+4.
  - else `npc_sel` selects `brj_addr`.
  - else `predict_taken` selects `predict_target`.
  - else `pc_q`+4.
  - Adds are mod 2^32.
- **PC update:**
  - `pc_q` loads next-PC when `pc_en` | `insert_priv_pc` | `rollback`.
  - Redirects are `insert_priv_pc`, `rollback` and `npc_sel`.
- **FETCH state:**
  - `imem_addr`=`pc_q`.
  - `imem_ren` = `iren` & ~`suppress_iren` & (`pc_q`[1:0]==0).
  - If a redirect loads `pc_q` while `imem_ren` & `imem_busy`: `hold_q`<=old `pc_q`, then go to DISCARD.
- **DISCARD state:**
  - `imem_addr`=`hold_q` and `imem_ren`=1, so the outstanding read completes unchanged.
  - When `imem_busy`=0, the returned word is dropped and the FSM returns to FETCH.
  - Further redirects in DISCARD update `pc_q` only.
- `i_mem_busy` = (`imem_ren` & `imem_busy`) | (state==DISCARD).
- **Misaligned PC** (`pc_q`[1:0]≠0, in FETCH):
  - No bus request.
  - Fetch completes immediately.
  - Latch gets `fe_mal_insn`=1 and `fe_instr`=NOP (32'h0000_0013).
- **IF/EX latch, per cycle:**
  - `if_ex_flush`: `fe_valid`<=0, `fe_instr`<=NOP, `fe_mal_insn`<=0. Flush overrides stall.
  - else `if_ex_stall`: hold all fields.
  - else:
    - `fe_valid` <= fetch completed in FETCH this cycle, i.e. (`imem_ren` & ~`imem_busy`) | misaligned.
    - `fe_instr` <= `imem_rdata` (or NOP).
    - `fe_pc` <= `pc_q`, `fe_pc4` <= `pc_q`+4.
    - `fe_pred_taken` <= `predict_taken`.
  - An incomplete fetch loads a bubble (`fe_valid`=0).

## Timing
- **Reset values:**
  - `pc_q`=`RESET_PC`, state=FETCH, `hold_q`=0.
  - `fe_valid`=0, `fe_instr`=NOP, `fe_pc`=`fe_pc4`=0, `fe_pred_taken`=0, `fe_mal_insn`=0.
  - `imem_ren` reflects `iren` combinationally after reset.
- `imem_addr`, `imem_ren` and `i_mem_busy` are combinational from state and registers. `i_mem_busy` also depends on `imem_busy`.
- **Zero-wait memory:** the instruction appears in IF/EX one cycle after `pc_q` presents. Sustained throughput is 1 instruction per cycle.
- **N-cycle busy:** `i_mem_busy` is high for N cycles. The hazard unit holds `pc_en`=0. A bubble enters IF/EX each busy cycle unless stalled.
- **Redirect during busy:** cost is the remaining busy cycles plus one fetch. `imem_addr` never changes while `imem_busy`=1.
- **Reset mid-transaction:** state returns to FETCH immediately. The bus must tolerate an abandoned read.

## Structure
- `word_t` comes from `rv32i_types_pkg`.
- Add to `stage3_types_pkg`:
  - `fetch_state_t` enum {FETCH, DISCARD}.
  - `RV32I_NOP` = 32'h0000_0013.
  - `fetch_ex_t` packed struct holding the IF/EX latch fields.
- Optional sub-module `stage3_npc_mux`: purely combinational next-PC priority selection.
- All state lives in the top module.

## Test plan
- **Zero-wait sequential fetch:** reset, then `iren`=1, `pc_en`=1, `imem_busy`=0. Expect `imem_addr` 0x8000_0000, 0x8000_0004, … and `fe_pc` to follow one cycle later with `fe_valid`=1.
- **Busy=3, then redirect in cycle 2:** `npc_sel`=1, `brj_addr`=0x100. Expect `imem_addr` held at the old PC until busy drops, the old word dropped (`fe_valid`=0), then a fetch from 0x100.
- **Simultaneous `insert_priv_pc`, `rollback`, `npc_sel`:** `priv_pc`=0x200. Expect `pc_f`=0x200. Then `rollback` alone with `pc_m`=0x40 gives `pc_f`=0x44.
- **Misaligned PC:** `brj_addr`=0x102. Expect `imem_ren`=0 and a latch with `fe_mal_insn`=1, `fe_instr`=0x0000_0013, `fe_pc`=0x102.
- **`if_ex_stall` and `if_ex_flush` asserted together:** expect `fe_valid`=0. Stall alone holds `fe_instr` across 3 cycles.
- **`RST` pulse mid-busy (DISCARD):** expect all reset values within the same cycle and state=FETCH.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I base types.
//   word_t : 32-bit machine word (addresses, instructions, data)
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/stage3_types_pkg.sv
// Types and constants for the three-stage pipeline fetch stage.
//   fetch_state_t : fetch FSM state encoding
//   RV32I_NOP     : addi x0, x0, 0
//   fetch_ex_t    : IF/EX latch contents
package stage3_types_pkg;
    import rv32i_types_pkg::*;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

    localparam word_t RV32I_NOP = 32'h0000_0013;

    typedef struct packed {
        logic  valid;
        word_t instr;
        word_t pc;
        word_t pc4;
        logic  pred_taken;
        logic  mal_insn;
    } fetch_ex_t;

endpackage

// File: rtl/stage3_fetch_stage_if.sv
// Instruction bus between the fetch stage and instruction memory.
//   imem_addr  : read address (requester -> memory)
//   imem_ren   : read request (requester -> memory)
//   imem_busy  : read not yet complete (memory -> requester)
//   imem_rdata : read data, valid in the cycle imem_busy is low
interface stage3_fetch_stage_if;
    import rv32i_types_pkg::*;

    word_t imem_addr;
    logic  imem_ren;
    logic  imem_busy;
    word_t imem_rdata;

    modport master (output imem_addr, output imem_ren,
                    input  imem_busy, input  imem_rdata);
    modport slave  (input  imem_addr, input  imem_ren,
                    output imem_busy, output imem_rdata);

endinterface

// File: rtl/stage3_npc_mux.sv
// Next-PC priority selection, purely combinational.
//   Priority: trap vector > rollback (pc_m+4) > branch/jump > prediction > pc+4.
//   Inputs : pc_q, insert_priv_pc/priv_pc, rollback/pc_m, npc_sel/brj_addr,
//            predict_taken/predict_target
//   Output : npc
module stage3_npc_mux
    import rv32i_types_pkg::*;
(
    input  word_t pc_q,
    input  logic  insert_priv_pc,
    input  word_t priv_pc,
    input  logic  rollback,
    input  word_t pc_m,
    input  logic  npc_sel,
    input  word_t brj_addr,
    input  logic  predict_taken,
    input  word_t predict_target,
    output word_t npc
);

    always_comb begin
        if (insert_priv_pc)     npc = priv_pc;
        else if (rollback)      npc = pc_m + 32'd4;
        else if (npc_sel)       npc = brj_addr;
        else if (predict_taken) npc = predict_target;
        else                    npc = pc_q + 32'd4;
    end

endmodule

// File: rtl/stage3_fetch_stage.sv
// Fetch stage: owns the fetch PC, issues instruction reads and fills the
// IF/EX latch. Steered by the hazard unit; reports bus busy back to it.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   FETCH   | bus addressed by pc_q; completed word goes to IF/EX
//   DISCARD | a redirect hit an outstanding read; keep hold_q on the bus
//           | until the read completes, then drop the returned word
//
// Ports: CLK/RST; hazard controls (pc_en, npc_sel, if_ex_stall, if_ex_flush,
// iren, suppress_iren, rollback, insert_priv_pc); redirect targets (priv_pc,
// brj_addr, pc_m); predictor (predict_taken, predict_target); imem bus
// (master modport); pc_f, i_mem_busy, rv32c_ready; IF/EX latch fe_*.
module stage3_fetch_stage
    import rv32i_types_pkg::*;
    import stage3_types_pkg::*;
#(
    parameter word_t RESET_PC = 32'h8000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  pc_en,
    input  logic  npc_sel,
    input  logic  if_ex_stall,
    input  logic  if_ex_flush,
    input  logic  iren,
    input  logic  suppress_iren,
    input  logic  rollback,
    input  logic  insert_priv_pc,
    input  word_t priv_pc,
    input  word_t brj_addr,
    input  word_t pc_m,
    input  logic  predict_taken,
    input  word_t predict_target,
    stage3_fetch_stage_if.master imem,
    output word_t pc_f,
    output logic  i_mem_busy,
    output logic  rv32c_ready,
    output logic  fe_valid,
    output word_t fe_instr,
    output word_t fe_pc,
    output word_t fe_pc4,
    output logic  fe_pred_taken,
    output logic  fe_mal_insn
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        hold_q, hold_d;
    fetch_ex_t    fe_q, fe_d;

    word_t npc;
    logic  redirect, pc_load, misaligned, fetch_done;

    stage3_npc_mux u_npc_mux (
        .pc_q           (pc_q),
        .insert_priv_pc (insert_priv_pc),
        .priv_pc        (priv_pc),
        .rollback       (rollback),
        .pc_m           (pc_m),
        .npc_sel        (npc_sel),
        .brj_addr       (brj_addr),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .npc            (npc)
    );

    assign redirect   = insert_priv_pc | rollback | npc_sel;
    assign pc_load    = pc_en | insert_priv_pc | rollback;
    assign misaligned = (state_q == FETCH) && (pc_q[1:0] != 2'b00);

    // DISCARD keeps the abandoned address on the bus so the memory sees an
    // unchanged request until it finishes.
    always_comb begin
        if (state_q == DISCARD) begin
            imem.imem_addr = hold_q;
            imem.imem_ren  = 1'b1;
        end else begin
            imem.imem_addr = pc_q;
            imem.imem_ren  = iren & ~suppress_iren & (pc_q[1:0] == 2'b00);
        end
    end

    assign fetch_done  = (state_q == FETCH) &&
                         ((imem.imem_ren & ~imem.imem_busy) | misaligned);
    assign i_mem_busy  = (imem.imem_ren & imem.imem_busy) | (state_q == DISCARD);
    assign pc_f        = pc_q;
    assign rv32c_ready = 1'b1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        fe_d    = fe_q;

        if (pc_load) pc_d = npc;

        case (state_q)
            FETCH: begin
                if (redirect && pc_load && imem.imem_ren && imem.imem_busy) begin
                    hold_d  = pc_q;
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (!imem.imem_busy) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        if (if_ex_flush) begin
            fe_d.valid    = 1'b0;
            fe_d.instr    = RV32I_NOP;
            fe_d.mal_insn = 1'b0;
        end else if (!if_ex_stall) begin
            fe_d.valid      = fetch_done;
            fe_d.instr      = misaligned ? RV32I_NOP : imem.imem_rdata;
            fe_d.pc         = pc_q;
            fe_d.pc4        = pc_q + 32'd4;
            fe_d.pred_taken = predict_taken;
            fe_d.mal_insn   = misaligned;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            fe_q    <= '{valid: 1'b0, instr: RV32I_NOP, pc: '0, pc4: '0,
                         pred_taken: 1'b0, mal_insn: 1'b0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            fe_q    <= fe_d;
        end
    end

    assign fe_valid      = fe_q.valid;
    assign fe_instr      = fe_q.instr;
    assign fe_pc         = fe_q.pc;
    assign fe_pc4        = fe_q.pc4;
    assign fe_pred_taken = fe_q.pred_taken;
    assign fe_mal_insn   = fe_q.mal_insn;

endmodule
